// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: shares one synchronous RAM read port between an
// instruction-fetch requester (0) and a data-load requester (1).
// Round-robin grant, address mux with idle hold, and a latency-matched
// tag pipeline that steers returning read data to the issuing requester.
module ram_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    input  logic                  req0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,

    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,

    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    localparam int unsigned LAST_STAGE = RD_LATENCY - 1;

    // One in-flight read: whether a grant happened and who owns it.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    logic                  prio_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    tag_t                  tag_q [RD_LATENCY];

    logic grant_any;
    logic grant_id;

    // Round-robin grant: a lone request always wins, a tie goes to prio_q.
    always_comb begin
        gnt0_o    = 1'b0;
        gnt1_o    = 1'b0;
        if (req0_i && req1_i) begin
            gnt0_o = ~prio_q;
            gnt1_o = prio_q;
        end else begin
            gnt0_o = req0_i;
            gnt1_o = req1_i;
        end
        grant_any = gnt0_o | gnt1_o;
        grant_id  = gnt1_o;
    end

    // Winner's address to the RAM; idle cycles re-read the last granted address.
    always_comb begin
        ram_addr_o = last_addr_q;
        if (gnt0_o) begin
            ram_addr_o = addr0_i;
        end else if (gnt1_o) begin
            ram_addr_o = addr1_i;
        end
    end

    // Priority flips to the loser on each grant; remember the granted address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prio_q      <= 1'b0;
            last_addr_q <= '0;
        end else if (gnt0_o) begin
            prio_q      <= 1'b1;
            last_addr_q <= addr0_i;
        end else if (gnt1_o) begin
            prio_q      <= 1'b0;
            last_addr_q <= addr1_i;
        end
    end

    // Tag shift register matched to the RAM read latency.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: grant_any, id: grant_id};
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Route the RAM data to the owner of the tag leaving the pipeline.
    always_comb begin
        rvalid0_o = tag_q[LAST_STAGE].valid & ~tag_q[LAST_STAGE].id;
        rvalid1_o = tag_q[LAST_STAGE].valid &  tag_q[LAST_STAGE].id;
        rdata0_o  = rvalid0_o ? ram_rdata_i : '0;
        rdata1_o  = rvalid1_o ? ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: three instances (read latency 1, 2, 3) share
// one stimulus stream; each has its own RAM model, and all are compared with
// a transaction-level reference (winner choice + grant history queue).
module tb_ram_read_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int NDUT = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;

    logic          gnt0    [NDUT];
    logic          gnt1    [NDUT];
    logic          rvalid0 [NDUT];
    logic          rvalid1 [NDUT];
    logic [DW-1:0] rdata0  [NDUT];
    logic [DW-1:0] rdata1  [NDUT];
    logic [AW-1:0] ram_addr  [NDUT];
    logic [DW-1:0] ram_rdata [NDUT];
    logic [DW-1:0] pipe [NDUT][4];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // RAM contents as a pure function of the address.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Synchronous RAM models: address sampled at the edge, data after LAT-1 more edges.
    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            pipe[i][0] <= mem_f(ram_addr[i]);
            for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end
    assign ram_rdata[0] = pipe[0][0];
    assign ram_rdata[1] = pipe[1][1];
    assign ram_rdata[2] = pipe[2][2];

    ram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0[0]), .rvalid0_o(rvalid0[0]), .rdata0_o(rdata0[0]),
        .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1[0]), .rvalid1_o(rvalid1[0]), .rdata1_o(rdata1[0]),
        .ram_addr_o(ram_addr[0]), .ram_rdata_i(ram_rdata[0]));

    ram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
        .clk_i(clk), .rstn_i(rstn),
        .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0[1]), .rvalid0_o(rvalid0[1]), .rdata0_o(rdata0[1]),
        .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1[1]), .rvalid1_o(rvalid1[1]), .rdata1_o(rdata1[1]),
        .ram_addr_o(ram_addr[1]), .ram_rdata_i(ram_rdata[1]));

    ram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0[2]), .rvalid0_o(rvalid0[2]), .rdata0_o(rdata0[2]),
        .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1[2]), .rvalid1_o(rvalid1[2]), .rdata1_o(rdata1[2]),
        .ram_addr_o(ram_addr[2]), .ram_rdata_i(ram_rdata[2]));

    // Reference model: who owns the tie, last granted address, and a
    // per-cycle grant history (front = grant taken at the most recent edge).
    typedef struct {
        bit            v;
        bit            id;
        logic [AW-1:0] a;
    } ent_t;

    int            m_prio;
    logic [AW-1:0] m_last;
    ent_t          hist [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        ent_t e;
        e.v = 1'b0; e.id = 1'b0; e.a = '0;
        m_prio = 0;
        m_last = '0;
        hist.delete();
        for (int k = 0; k < 4; k++) hist.push_back(e);
    endtask

    task automatic model_push(input bit v, input bit id, input logic [AW-1:0] a);
        ent_t e;
        e.v = v; e.id = id; e.a = a;
        hist.push_front(e);
        void'(hist.pop_back());
    endtask

    // Compare every instance against the model for the current input state.
    task automatic check_all(output int winner);
        ent_t          r;
        logic [AW-1:0] exp_addr;
        winner = -1;
        if (req0 && req1)  winner = m_prio;
        else if (req0)     winner = 0;
        else if (req1)     winner = 1;
        exp_addr = (winner == 0) ? addr0 : (winner == 1) ? addr1 : m_last;
        for (int i = 0; i < NDUT; i++) begin
            r = hist[i];
            check($sformatf("L%0d gnt0", i+1), 64'(gnt0[i]), 64'(winner == 0));
            check($sformatf("L%0d gnt1", i+1), 64'(gnt1[i]), 64'(winner == 1));
            check($sformatf("L%0d ram_addr", i+1), 64'(ram_addr[i]), 64'(exp_addr));
            check($sformatf("L%0d rvalid0", i+1), 64'(rvalid0[i]), 64'(r.v && !r.id));
            check($sformatf("L%0d rvalid1", i+1), 64'(rvalid1[i]), 64'(r.v && r.id));
            check($sformatf("L%0d rdata0", i+1), 64'(rdata0[i]), 64'((r.v && !r.id) ? mem_f(r.a) : '0));
            check($sformatf("L%0d rdata1", i+1), 64'(rdata1[i]), 64'((r.v && r.id) ? mem_f(r.a) : '0));
        end
    endtask

    // One clock cycle of stimulus; optionally requester 1 withdraws mid-cycle.
    task automatic step(input bit r0, input logic [AW-1:0] a0,
                        input bit r1, input logic [AW-1:0] a1, input bit wd1);
        int winner;
        @(negedge clk);
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
        #1;
        if (wd1) begin
            check_all(winner);
            req1 = 1'b0;
            #1;
        end
        check_all(winner);
        if (winner == 0) begin
            m_prio = 1; m_last = addr0;
            model_push(1'b1, 1'b0, addr0);
        end else if (winner == 1) begin
            m_prio = 0; m_last = addr1;
            model_push(1'b1, 1'b1, addr1);
        end else begin
            model_push(1'b0, 1'b0, '0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle, held for n cycles, released at a falling edge.
    task automatic reset_dut(input int n);
        int winner;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        #1 rstn = 1'b0;
        #1;
        model_clear();
        check_all(winner);
        req0 = 1'b1; addr0 = 32'h0000_0123;
        #1;
        check_all(winner);
        req0 = 1'b0;
        repeat (n) @(negedge clk);
        rstn = 1'b1;
        model_push(1'b0, 1'b0, '0);
    endtask

    initial begin
        rstn = 1'b0;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        model_clear();
        reset_dut(2);

        // Single requester
        step(1'b1, 32'h100, 1'b0, '0, 1'b0);
        idle(4);

        // Contention from reset: alternating grants
        reset_dut(1);
        for (int k = 0; k < 4; k++) step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
        idle(4);

        // Idle hold of the last granted address
        step(1'b0, '0, 1'b1, 32'h44, 1'b0);
        idle(3);

        // Back-to-back grants 0,1,0
        step(1'b1, 32'h0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 32'h4, 1'b0);
        step(1'b1, 32'h8, 1'b0, '0, 1'b0);
        idle(4);

        // Reset with reads in flight
        step(1'b1, 32'h200, 1'b0, '0, 1'b0);
        reset_dut(2);
        idle(4);

        // Withdrawal with prio on requester 1
        step(1'b1, 32'h30, 1'b0, '0, 1'b0);
        step(1'b1, 32'h34, 1'b1, 32'h38, 1'b1);
        step(1'b1, 32'h3C, 1'b1, 32'h40, 1'b0);
        idle(3);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 79) == 0) begin
                reset_dut(int'($urandom_range(1, 2)));
            end else begin
                step(1'($urandom_range(0, 3) != 0), $urandom,
                     1'($urandom_range(0, 3) != 0), $urandom,
                     1'($urandom_range(0, 15) == 0));
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_read_arbiter.md
# ram_read_arbiter

Two-requester arbiter that shares one synchronous RAM read port (address out, read data in, fixed read latency) between requester 0 (instruction fetch) and requester 1 (data load). It grants one request per cycle using round-robin priority and drives the winner's address to the RAM. It tracks in-flight reads in a latency-matched tag pipeline and returns each read-data word with a valid strobe to the requester that issued it. It sits between the core's fetch/LSU units and the RAM slave port.

## Interface
Parameters:
- ADDR_WIDTH, 32, RAM address width
- DATA_WIDTH, 32, RAM data width
- RD_LATENCY, 1, cycles from the address-sampling edge to valid `ram_rdata_i`; legal range 1..4

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rstn_i  input  1  reset; one clock; reset is asynchronous and active-low
- req0_i  input  1  requester 0 read request
- addr0_i  input  ADDR_WIDTH  requester 0 address, valid while req0_i=1
- gnt0_o  output  1  requester 0 granted this cycle (combinational)
- rvalid0_o  output  1  rdata0_o holds requester 0 read data
- rdata0_o  output  DATA_WIDTH  requester 0 read data
- req1_i, addr1_i, gnt1_o, rvalid1_o, rdata1_o: same as above, for requester 1
- ram_addr_o  output  ADDR_WIDTH  address to RAM (MASTER side: addr)
- ram_rdata_i  input  DATA_WIDTH  data from RAM (MASTER side: rdata)

## Operation
- Handshake: a requester holds req/addr stable until it sees gnt=1 in the same cycle. The transfer completes on that rising edge. One transfer per cycle in total; back-to-back grants are allowed.
- Arbitration:
  - Only one request: it is granted.
  - Both requests: the owner of `prio_q` wins.
  - No request: no grant.
  - `prio_q` (1 bit, reset 0) updates only on a grant, to the non-granted index. Example: grant to 0 sets `prio_q`=1, so a persistently requesting loser wins the next cycle. Starvation bound is 1 cycle.
- gnt0_o and gnt1_o are never both 1. Grant does not depend on response state, because the pipeline never backpressures.
- Address mux:
  - ram_addr_o = addr of the granted requester.
  - With no grant, ram_addr_o holds `last_addr_q`, the address of the most recent grant (reset 0). An idle RAM therefore re-reads a stable address and the bus does not toggle.
  - `last_addr_q` updates on every grant.
- Tag pipeline:
  - RD_LATENCY stages. Each stage is {valid, id}.
  - Stage 0 loads {grant_any, granted_id} each edge; stage k loads stage k-1.
  - The last stage drives the responses: rvalid0_o = valid & (id==0); rvalid1_o = valid & (id==1).
- Data: rdata0_o and rdata1_o are gated to ram_rdata_i while their rvalid is 1, and are 0 otherwise.
- Idle re-reads (no grant) produce valid=0 tags, so no response is issued.

## Timing
- Reset values:
  - gnt0_o/gnt1_o follow the requests combinationally.
  - rvalid0_o=rvalid1_o=0 and rdata0_o=rdata1_o=0.
  - ram_addr_o=0 when no request is pending.
  - prio_q=0, all tag stages invalid.
- Grant latency: 0 cycles (combinational req -> gnt).
- Response latency: a grant sampled at edge N gives rvalid high in the cycle after edge N+RD_LATENCY-1, aligned with ram_rdata_i. For RD_LATENCY=1, rvalid is high the cycle right after the grant cycle.
- Throughput: 1 read/cycle sustained. With both requesters requesting continuously, grants alternate 0,1,0,1…
- Simultaneous requests on the first cycle after reset: requester 0 wins (prio_q=0).
- Requests withdrawn before grant are legal. No state changes and prio_q is unchanged.
- Reset asserted mid-operation:
  - All in-flight tags are dropped immediately (asynchronous), and no rvalid is issued for them after reset release.
  - prio_q and last_addr_q clear.
- ram_rdata_i is never registered inside the block. The RAM provides the latency.

## Test plan
- Single requester, RD_LATENCY=1: req0 with addr 0x100 for one cycle. Expect gnt0=1 that cycle, ram_addr_o=0x100, and rvalid0=1 with rdata0=mem[0x100] the next cycle. rvalid1 stays 0 throughout.
- Contention: req0 (0x10) and req1 (0x20) held continuously from reset. Expect grants 0,1,0,1 on consecutive cycles, ram_addr_o 0x10,0x20,0x10,0x20, and responses routed in the same order one cycle later.
- Idle hold: grant req1 at 0x44, then no requests for 3 cycles. Expect ram_addr_o=0x44 for all 3 cycles and no rvalid after the first response.
- RD_LATENCY=3: back-to-back grants 0 (0x0), 1 (0x4), 0 (0x8). Expect rvalid pattern 0,1,0 starting exactly 3 cycles after the first grant, each with matching data.
- Reset mid-flight, RD_LATENCY=2: grant req0, then drop rstn_i in the next cycle. Expect rvalid0/1, prio_q, and ram_addr_o idle value all 0 immediately. No response appears after release.
- Request withdrawal: req0 and req1 both asserted with prio_q=1; req1 withdraws before the edge. Expect gnt0=1 and prio_q=1 afterward.
